// File: rtl/core_unit_bist.sv
// Self-test of data memory, ALU and immediate extender; finish/pass valid 76 cycles after start is sampled.
// No backpressure: start is a level request and finish holds in DONE until start drops.

module dmem_unit (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module alu_unit (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = a + b;
      3'b001:  result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = {31'd0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

module ext_unit (
  input  logic [1:0]  op,
  input  logic [15:0] imm,
  output logic [31:0] result
);
  always_comb begin
    result = '0;
    case (op)
      2'b00:   result = {16'd0, imm};
      2'b01:   result = {{16{imm[15]}}, imm};
      2'b10:   result = {imm, 16'd0};
      default: result = '0;
    endcase
  end
endmodule

module core_unit_bist (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inject,
  output logic       finish,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DM = 3'd1, S_ALU = 3'd2, S_EXT = 3'd3, S_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } alu_vec_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] imm;
    logic [31:0] res;
  } ext_vec_t;

  function automatic logic [31:0] dm_pattern(input logic [4:0] i);
    return ({27'd0, i} * 32'h0101_0101) ^ 32'hA5A5_A5A5;
  endfunction

  function automatic alu_vec_t alu_rom(input logic [2:0] idx);
    alu_rom = '0;
    case (idx)
      3'd0: alu_rom = '{op: 3'b000, a: 32'h7FFF_FFFF, b: 32'h1,         res: 32'h8000_0000, zero: 1'b0};
      3'd1: alu_rom = '{op: 3'b001, a: 32'h0,         b: 32'h1,         res: 32'hFFFF_FFFF, zero: 1'b0};
      3'd2: alu_rom = '{op: 3'b010, a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, res: 32'hF000_F000, zero: 1'b0};
      3'd3: alu_rom = '{op: 3'b011, a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, res: 32'hFFF0_FFF0, zero: 1'b0};
      3'd4: alu_rom = '{op: 3'b100, a: 32'hFFFF_FFFF, b: 32'h1,         res: 32'h1,         zero: 1'b0};
      3'd5: alu_rom = '{op: 3'b100, a: 32'h1,         b: 32'hFFFF_FFFF, res: 32'h0,         zero: 1'b1};
      3'd6: alu_rom = '{op: 3'b001, a: 32'h5,         b: 32'h5,         res: 32'h0,         zero: 1'b1};
      default: alu_rom = '{op: 3'b000, a: 32'hFFFF_FFFF, b: 32'h1,      res: 32'h0,         zero: 1'b1};
    endcase
  endfunction

  function automatic ext_vec_t ext_rom(input logic [1:0] idx);
    ext_rom = '0;
    case (idx)
      2'd0:    ext_rom = '{op: 2'b00, imm: 16'h8001, res: 32'h0000_8001};
      2'd1:    ext_rom = '{op: 2'b01, imm: 16'h8001, res: 32'hFFFF_8001};
      2'd2:    ext_rom = '{op: 2'b10, imm: 16'h8001, res: 32'h8001_0000};
      default: ext_rom = '{op: 2'b01, imm: 16'h7FFF, res: 32'h0000_7FFF};
    endcase
  endfunction

  state_t      state, state_nxt;
  logic [5:0]  step, step_nxt;
  logic [7:0]  err_cnt;
  alu_vec_t    alu_v;
  ext_vec_t    ext_v;
  logic        dm_we;
  logic [31:0] dm_rdata, alu_result, ext_result;
  logic        alu_zero;
  logic        cmp_vld, zero_bad, mismatch;
  logic [31:0] unit_res, exp_res;

  assign alu_v = alu_rom(step[2:0]);
  assign ext_v = ext_rom(step[1:0]);

  dmem_unit u_dmem (.clk(clk), .we(dm_we), .addr(step[4:0]), .wdata(dm_pattern(step[4:0])), .rdata(dm_rdata));
  alu_unit  u_alu  (.op(alu_v.op), .a(alu_v.a), .b(alu_v.b), .result(alu_result), .zero(alu_zero));
  ext_unit  u_ext  (.op(ext_v.op), .imm(ext_v.imm), .result(ext_result));

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    dm_we     = 1'b0;
    cmp_vld   = 1'b0;
    zero_bad  = 1'b0;
    unit_res  = '0;
    exp_res   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_DM;
          step_nxt  = '0;
        end
      end
      S_DM: begin
        // Lower half of the phase fills memory, upper half reads it back.
        dm_we    = ~step[5];
        cmp_vld  = step[5];
        unit_res = dm_rdata;
        exp_res  = dm_pattern(step[4:0]);
        step_nxt = step + 6'd1;
        if (step == 6'd63) begin
          state_nxt = S_ALU;
          step_nxt  = '0;
        end
      end
      S_ALU: begin
        cmp_vld  = 1'b1;
        unit_res = alu_result;
        exp_res  = alu_v.res;
        zero_bad = (alu_zero != alu_v.zero);
        step_nxt = step + 6'd1;
        if (step == 6'd7) begin
          state_nxt = S_EXT;
          step_nxt  = '0;
        end
      end
      S_EXT: begin
        cmp_vld  = 1'b1;
        unit_res = ext_result;
        exp_res  = ext_v.res;
        step_nxt = step + 6'd1;
        if (step == 6'd3) begin
          state_nxt = S_DONE;
          step_nxt  = '0;
        end
      end
      S_DONE: begin
        if (!start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mismatch = cmp_vld && ((((unit_res ^ {31'd0, inject}) != exp_res)) || zero_bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      step    <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      if (state == S_IDLE && start) err_cnt <= '0;
      else if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign finish    = (state == S_DONE);
  assign pass      = finish && (err_cnt == 8'd0);
  assign err_count = err_cnt;
  assign phase     = state;
endmodule

// File: tb/tb_core_unit_bist.sv
// Bench for core_unit_bist: unit vector tables plus full-run scenarios against an edge-level error model.
module tb_core_unit_bist;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       inject = 1'b0;
  logic       finish, pass;
  logic [7:0] err_count;
  logic [2:0] phase;

  logic [2:0]  t_op;
  logic [31:0] t_a, t_b, t_res;
  logic        t_zero;
  logic [1:0]  t_eop;
  logic [15:0] t_imm;
  logic [31:0] t_eres;
  logic        t_we = 1'b0;
  logic [4:0]  t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [31:0] t_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_unit_bist dut (
    .clk(clk), .rst(rst), .start(start), .inject(inject),
    .finish(finish), .pass(pass), .err_count(err_count), .phase(phase)
  );
  alu_unit  u_alu (.op(t_op), .a(t_a), .b(t_b), .result(t_res), .zero(t_zero));
  ext_unit  u_ext (.op(t_eop), .imm(t_imm), .result(t_eres));
  dmem_unit u_dm  (.clk(clk), .we(t_we), .addr(t_addr), .wdata(t_wdata), .rdata(t_rdata));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } alu_tv_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] imm;
    logic [31:0] res;
  } ext_tv_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op)
      3'd0: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd1: return 32'((longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ext_model(input logic [1:0] op, input logic [15:0] imm);
    int v = int'(imm);
    case (op)
      2'd0: return 32'(v);
      2'd1: return (v >= 32768) ? 32'(v - 65536) : 32'(v);
      2'd2: return 32'(v * 65536);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] dm_data(input int i);
    return 32'(i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
  endfunction

  // mode: 0 clean, 1 inject always, 2 inject only on ALU edges, 3 random inject per edge.
  // Compared steps commit on edges 33..76, so the model counts injected edges in that window.
  task automatic run_bist(input int mode, input string tag);
    int exp_err = 0;
    int lat = -1;
    start = 1'b1;
    tick();
    for (int e = 1; e <= 200; e++) begin
      case (mode)
        0:       inject = 1'b0;
        1:       inject = 1'b1;
        2:       inject = (e >= 65 && e <= 72);
        default: inject = 1'($urandom_range(0, 1));
      endcase
      if (e >= 33 && e <= 76 && inject) exp_err++;
      tick();
      if (e == 1)  chk({tag, "_phase_dm"}, 32'(phase), 32'd1);
      if (e == 64) chk({tag, "_phase_alu"}, 32'(phase), 32'd2);
      if (e == 72) chk({tag, "_phase_ext"}, 32'(phase), 32'd3);
      if (finish) begin
        lat = e;
        break;
      end
    end
    inject = 1'b0;
    chk({tag, "_latency"}, lat, 32'd76);
    chk({tag, "_finish"}, 32'(finish), 32'd1);
    chk({tag, "_pass"}, 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    chk({tag, "_phase_done"}, 32'(phase), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    alu_tv_t alu_tv[$];
    ext_tv_t ext_tv[$];
    logic [31:0] dm_ref [32];
    int lat;

    alu_tv.push_back('{3'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0});
    alu_tv.push_back('{3'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0});
    alu_tv.push_back('{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
    alu_tv.push_back('{3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0});
    alu_tv.push_back('{3'd4, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0});
    alu_tv.push_back('{3'd4, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1});
    alu_tv.push_back('{3'd1, 32'h5,         32'h5,         32'h0,         1'b1});
    alu_tv.push_back('{3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1});
    for (int i = 0; i < 16; i++) begin
      alu_tv_t v;
      v.op   = 3'($urandom_range(0, 4));
      v.a    = $urandom;
      v.b    = (i % 4 == 0) ? v.a : $urandom;
      v.res  = alu_model(v.op, v.a, v.b);
      v.zero = (v.res == 32'd0);
      alu_tv.push_back(v);
    end

    ext_tv.push_back('{2'd0, 16'h8001, 32'h0000_8001});
    ext_tv.push_back('{2'd1, 16'h8001, 32'hFFFF_8001});
    ext_tv.push_back('{2'd2, 16'h8001, 32'h8001_0000});
    ext_tv.push_back('{2'd1, 16'h7FFF, 32'h0000_7FFF});
    for (int i = 0; i < 8; i++) begin
      ext_tv_t v;
      v.op  = 2'($urandom_range(0, 2));
      v.imm = 16'($urandom);
      v.res = ext_model(v.op, v.imm);
      ext_tv.push_back(v);
    end

    #12;
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_finish", 32'(finish), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_err", 32'(err_count), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    foreach (alu_tv[i]) begin
      t_op = alu_tv[i].op; t_a = alu_tv[i].a; t_b = alu_tv[i].b;
      #1;
      chk($sformatf("alu_res_%0d", i), t_res, alu_tv[i].res);
      chk($sformatf("alu_zero_%0d", i), 32'(t_zero), 32'(alu_tv[i].zero));
    end
    foreach (ext_tv[i]) begin
      t_eop = ext_tv[i].op; t_imm = ext_tv[i].imm;
      #1;
      chk($sformatf("ext_res_%0d", i), t_eres, ext_tv[i].res);
    end

    for (int i = 0; i < 32; i++) begin
      t_we = 1'b1; t_addr = 5'(i); t_wdata = dm_data(i);
      dm_ref[i] = dm_data(i);
      tick();
    end
    t_we = 1'b0;
    t_addr = 5'd3;
    #1;
    chk("dm_read_addr3", t_rdata, dm_data(3));
    for (int i = 0; i < 6; i++) begin
      t_addr = 5'($urandom_range(0, 31));
      #1;
      chk($sformatf("dm_read_%0d", t_addr), t_rdata, dm_ref[t_addr]);
    end

    run_bist(0, "clean");
    repeat (3) tick();
    chk("hold_finish", 32'(finish), 32'd1);
    start = 1'b0;
    tick();
    chk("drop_finish", 32'(finish), 32'd0);
    chk("drop_phase", 32'(phase), 32'd0);
    chk("drop_pass", 32'(pass), 32'd0);

    run_bist(1, "inject_all");
    start = 1'b0;
    tick();
    chk("idle_err_held", 32'(err_count), 32'd44);
    chk("idle_phase", 32'(phase), 32'd0);

    run_bist(2, "inject_alu");
    start = 1'b0;
    tick();

    start = 1'b1;
    inject = 1'b1;
    tick();
    repeat (40) tick();
    rst = 1'b0;
    #1;
    chk("midrst_phase", 32'(phase), 32'd0);
    chk("midrst_err", 32'(err_count), 32'd0);
    chk("midrst_finish", 32'(finish), 32'd0);
    inject = 1'b0;
    #2;
    rst = 1'b1;
    run_bist(0, "after_reset");
    start = 1'b0;
    tick();

    // start dropped right after being sampled: run still completes, then DONE exits at once
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (finish) begin
        lat = e;
        break;
      end
    end
    chk("startdrop_latency", lat, 32'd76);
    chk("startdrop_pass", 32'(pass), 32'd1);
    tick();
    chk("startdrop_exit_phase", 32'(phase), 32'd0);
    chk("startdrop_exit_finish", 32'(finish), 32'd0);

    for (int r = 0; r < 3; r++) begin
      run_bist(3, $sformatf("random%0d", r));
      start = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
